// File: rtl/conv_job_ctrl_if.sv
// Signal bundle between the convolution job controller and its environment
// (job requester, weight RAM, upstream window stream, conv engine, result sink).
interface conv_job_ctrl_if #(
  parameter int DataWidth  = 32,
  parameter int KernelSize = 9,
  parameter int MaxWindows = 1024
);
  localparam int CntW  = $clog2(MaxWindows + 1);
  localparam int AddrW = $clog2(KernelSize);
  localparam int WinW  = KernelSize * DataWidth;

  logic                 start;
  logic [CntW-1:0]      num_windows;
  logic [AddrW-1:0]     wt_rd_addr;
  logic [DataWidth-1:0] wt_rd_data;
  logic [WinW-1:0]      win_data;
  logic                 win_valid;
  logic                 win_ready;
  logic                 conv_rst;
  logic [DataWidth-1:0] conv_weight;
  logic                 conv_weight_valid;
  logic [WinW-1:0]      conv_window;
  logic                 conv_window_valid;
  logic [DataWidth-1:0] conv_result;
  logic                 conv_result_ready;
  logic [DataWidth-1:0] res_data;
  logic                 res_valid;
  logic [CntW-1:0]      res_idx;
  logic                 busy;
  logic                 done;
  logic                 overrun;

  // Environment side: requester, RAM, upstream stream and engine.
  modport master (
    output start, num_windows, wt_rd_data, win_data, win_valid,
           conv_result, conv_result_ready,
    input  wt_rd_addr, win_ready, conv_rst, conv_weight, conv_weight_valid,
           conv_window, conv_window_valid, res_data, res_valid, res_idx,
           busy, done, overrun
  );

  // Controller side.
  modport slave (
    input  start, num_windows, wt_rd_data, win_data, win_valid,
           conv_result, conv_result_ready,
    output wt_rd_addr, win_ready, conv_rst, conv_weight, conv_weight_valid,
           conv_window, conv_window_valid, res_data, res_valid, res_idx,
           busy, done, overrun
  );
endinterface

// File: rtl/conv_job_ctrl.sv
// Job sequencer for a 3x3 convolution engine: engine reset, serial weight load,
// window forwarding with upstream backpressure, result tagging and done pulse.
module conv_job_ctrl #(
  parameter int DataWidth  = 32,
  parameter int KernelSize = 9,
  parameter int MaxWindows = 1024
) (
  input  logic          Clk,
  input  logic          Rst,
  conv_job_ctrl_if.slave bus
);
  localparam int CntW  = $clog2(MaxWindows + 1);
  localparam int AddrW = $clog2(KernelSize);
  localparam int LdW   = $clog2(KernelSize + 1);
  localparam int WinW  = KernelSize * DataWidth;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [LdW-1:0]       r_phase;
  logic [CntW-1:0]      r_n_req;
  logic [CntW-1:0]      r_issued;
  logic [CntW-1:0]      r_received;
  logic                 r_wt_vld_p1;
  logic                 r_win_vld_p1;
  logic [WinW-1:0]      r_win_p1;
  logic                 r_res_vld_p1;
  logic [DataWidth-1:0] r_res_data_p1;
  logic [CntW-1:0]      r_res_idx_p1;
  logic                 r_overrun;

  logic w_start_acc;
  logic w_load_rd;
  logic w_win_rdy;
  logic w_win_hs;
  logic w_res_acc;
  logic w_rcv_all;

  assign w_start_acc = (r_state == S_IDLE) && bus.start;
  // LOAD spends KernelSize cycles addressing the RAM plus one to catch the last word.
  assign w_load_rd   = (r_state == S_LOAD) && (r_phase < LdW'(KernelSize));
  assign w_win_rdy   = (r_state == S_STREAM) && (r_issued < r_n_req);
  assign w_win_hs    = w_win_rdy && bus.win_valid;
  assign w_res_acc   = bus.conv_result_ready
                    && ((r_state == S_STREAM) || (r_state == S_DRAIN))
                    && (r_received < r_n_req);
  // Look ahead so done lands in the same cycle as the last res_valid.
  assign w_rcv_all   = (r_received == r_n_req)
                    || (w_res_acc && ((r_received + CntW'(1)) == r_n_req));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_state_nxt = S_CLEAR;
      S_CLEAR:  if (r_phase == LdW'(1)) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (r_phase == LdW'(KernelSize)) begin
          w_state_nxt = (r_n_req == '0) ? S_DONE : S_STREAM;
        end
      end
      S_STREAM: if (r_issued == r_n_req) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (w_rcv_all) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_n_req    <= '0;
      r_issued   <= '0;
      r_received <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_phase <= '0;
      end else if ((r_state == S_CLEAR) || (r_state == S_LOAD)) begin
        r_phase <= r_phase + LdW'(1);
      end
      if (w_start_acc) begin
        r_n_req    <= bus.num_windows;
        r_issued   <= '0;
        r_received <= '0;
      end else begin
        if (w_win_hs)  r_issued   <= r_issued + CntW'(1);
        if (w_res_acc) r_received <= r_received + CntW'(1);
      end
      if (bus.conv_result_ready && !w_res_acc) r_overrun <= 1'b1;
    end
  end

  // Stage p1: weight valid, forwarded window and tagged result.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wt_vld_p1   <= 1'b0;
      r_win_vld_p1  <= 1'b0;
      r_win_p1      <= '0;
      r_res_vld_p1  <= 1'b0;
      r_res_data_p1 <= '0;
      r_res_idx_p1  <= '0;
    end else begin
      r_wt_vld_p1  <= w_load_rd;
      r_win_vld_p1 <= w_win_hs;
      r_res_vld_p1 <= w_res_acc;
      if (w_win_hs) r_win_p1 <= bus.win_data;
      if (w_res_acc) begin
        r_res_data_p1 <= bus.conv_result;
        r_res_idx_p1  <= r_received;
      end
    end
  end

  // The RAM's own output register supplies the one-cycle weight delay.
  assign bus.wt_rd_addr        = w_load_rd ? r_phase[AddrW-1:0] : '0;
  assign bus.conv_weight       = r_wt_vld_p1 ? bus.wt_rd_data : '0;
  assign bus.conv_weight_valid = r_wt_vld_p1;
  assign bus.conv_rst          = Rst || (r_state == S_CLEAR);
  assign bus.win_ready         = w_win_rdy;
  assign bus.conv_window       = r_win_p1;
  assign bus.conv_window_valid = r_win_vld_p1;
  assign bus.res_data          = r_res_data_p1;
  assign bus.res_valid         = r_res_vld_p1;
  assign bus.res_idx           = r_res_idx_p1;
  assign bus.busy              = (r_state != S_IDLE);
  assign bus.done              = (r_state == S_DONE);
  assign bus.overrun           = r_overrun;

endmodule

// File: tb/tb_conv_job_ctrl.sv
// Directed bench for conv_job_ctrl with a sync weight RAM and a fixed-latency engine model.
module tb_conv_job_ctrl;
  localparam int DW  = 32;
  localparam int KS  = 9;
  localparam int MW  = 1024;
  localparam int CW  = $clog2(MW + 1);
  localparam int WW  = KS * DW;
  localparam logic [DW-1:0] F1  = 32'h3F800000;
  localparam logic [DW-1:0] F2  = 32'h40000000;
  localparam logic [DW-1:0] F18 = 32'h41900000;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic inj = 1'b0;
  logic [2:0] eng_pipe = '0;
  logic [DW-1:0] mem [KS];
  int n_chk = 0;
  int n_fail = 0;

  conv_job_ctrl_if #(.DataWidth(DW), .KernelSize(KS), .MaxWindows(MW)) bus ();

  conv_job_ctrl #(.DataWidth(DW), .KernelSize(KS), .MaxWindows(MW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) bus.wt_rd_data <= mem[bus.wt_rd_addr];

  // Engine: result three cycles after each window, flushed by conv_rst.
  always @(posedge Clk) begin
    if (bus.conv_rst) eng_pipe <= '0;
    else              eng_pipe <= {eng_pipe[1:0], bus.conv_window_valid};
  end
  assign bus.conv_result_ready = eng_pipe[2] | inj;
  assign bus.conv_result       = F18;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_win(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] mk_win(input int k);
    logic [WW-1:0] w;
    for (int i = 0; i < KS; i++) w[i*DW +: DW] = F2;
    w[DW-1:0] = F2 + 32'(k);
    return w;
  endfunction

  task automatic check_idle(input string tag, input logic exp_rst, input logic exp_ovr);
    check({tag, "_conv_rst"}, 64'(bus.conv_rst), 64'(exp_rst));
    check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    check({tag, "_done"}, 64'(bus.done), 64'(0));
    check({tag, "_win_ready"}, 64'(bus.win_ready), 64'(0));
    check({tag, "_wt_addr"}, 64'(bus.wt_rd_addr), 64'(0));
    check({tag, "_weight"}, 64'(bus.conv_weight), 64'(0));
    check({tag, "_weight_valid"}, 64'(bus.conv_weight_valid), 64'(0));
    check_win({tag, "_window"}, bus.conv_window, '0);
    check({tag, "_window_valid"}, 64'(bus.conv_window_valid), 64'(0));
    check({tag, "_res_data"}, 64'(bus.res_data), 64'(0));
    check({tag, "_res_valid"}, 64'(bus.res_valid), 64'(0));
    check({tag, "_res_idx"}, 64'(bus.res_idx), 64'(0));
    check({tag, "_overrun"}, 64'(bus.overrun), 64'(exp_ovr));
  endtask

  // Runs one job from the IDLE cycle in which start is raised; c counts cycles after it.
  task automatic run_job(input int n, input bit gaps, input bit spam, input logic exp_ovr);
    int  hs = 0;
    int  rcv = 0;
    int  dones = 0;
    int  fin_c = 0;
    bit  fin = 0;
    bit  prev_hs = 0;
    bit  prev_rdy = 0;
    bit  exp_wr;
    bit  exp_done;
    bus.num_windows = CW'(n);
    bus.win_valid = 1'b0;
    bus.start = 1'b1;
    tick();
    for (int c = 1; c <= 200 && !(fin && c > fin_c + 1); c++) begin
      bus.start       = spam && (c == 5 || c == 14);
      bus.num_windows = bus.start ? CW'(7) : CW'(n);
      bus.win_valid   = gaps ? (c % 3 == 1) : 1'b1;
      bus.win_data    = mk_win(hs);
      exp_wr = (c >= 13) && (hs < n) && !fin;
      check("busy", 64'(bus.busy), 64'(!fin));
      check("conv_rst", 64'(bus.conv_rst), 64'(c <= 2));
      check("weight_valid", 64'(bus.conv_weight_valid), 64'(c >= 4 && c <= 12));
      if (c >= 4 && c <= 12) check("weight", 64'(bus.conv_weight), 64'(mem[c-4]));
      if (c >= 3 && c <= 11) check("wt_addr", 64'(bus.wt_rd_addr), 64'(c - 3));
      check("win_ready", 64'(bus.win_ready), 64'(exp_wr));
      check("window_valid", 64'(bus.conv_window_valid), 64'(prev_hs));
      if (prev_hs) check_win("window", bus.conv_window, mk_win(hs - 1));
      check("res_valid", 64'(bus.res_valid), 64'(prev_rdy));
      if (prev_rdy) begin
        check("res_idx", 64'(bus.res_idx), 64'(rcv));
        check("res_data", 64'(bus.res_data), 64'(F18));
        rcv++;
      end
      exp_done = (n == 0) ? (c == 13) : (prev_rdy && rcv == n);
      check("done", 64'(bus.done), 64'(exp_done));
      check("overrun", 64'(bus.overrun), 64'(exp_ovr));
      if (bus.done === 1'b1) begin
        dones++;
        if (!fin) fin_c = c;
        fin = 1;
      end
      prev_hs = bus.win_valid && exp_wr;
      if (prev_hs) hs++;
      prev_rdy = bus.conv_result_ready;
      tick();
    end
    bus.start = 1'b0;
    bus.win_valid = 1'b0;
    check("job_finished", 64'(fin), 64'(1));
    check("done_count", 64'(dones), 64'(1));
    check("results_seen", 64'(rcv), 64'(n));
    check("windows_sent", 64'(hs), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < KS; i++) mem[i] = F1;
    bus.start = 1'b0;
    bus.num_windows = '0;
    bus.win_valid = 1'b0;
    bus.win_data = '0;

    // Reset state
    tick();
    tick();
    check_idle("rst", 1'b1, 1'b0);
    Rst = 1'b0;
    #1;
    check_idle("post_rst", 1'b0, 1'b0);
    tick();

    // Basic job, gapped upstream, empty job, ignored restarts
    run_job(4, 1'b0, 1'b0, 1'b0);
    run_job(4, 1'b1, 1'b0, 1'b0);
    run_job(0, 1'b0, 1'b0, 1'b0);
    run_job(4, 1'b0, 1'b1, 1'b0);

    // Abort three cycles into STREAM with results in flight
    bus.num_windows = CW'(4);
    bus.win_data = mk_win(0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.win_valid = 1'b1;
    repeat (15) tick();
    check("pre_abort_busy", 64'(bus.busy), 64'(1));
    Rst = 1'b1;
    bus.win_valid = 1'b0;
    #1;
    check("abort_conv_rst", 64'(bus.conv_rst), 64'(1));
    tick();
    Rst = 1'b0;
    #1;
    check_idle("abort", 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_res", 64'(bus.res_valid), 64'(0));
      check("abort_no_done", 64'(bus.done), 64'(0));
      check("abort_no_ovr", 64'(bus.overrun), 64'(0));
    end
    run_job(4, 1'b0, 1'b0, 1'b0);

    // Stray engine result while idle
    inj = 1'b1;
    tick();
    inj = 1'b0;
    check("inj_overrun", 64'(bus.overrun), 64'(1));
    check("inj_res_valid", 64'(bus.res_valid), 64'(0));
    tick();
    check("inj_res_valid2", 64'(bus.res_valid), 64'(0));
    run_job(2, 1'b0, 1'b0, 1'b1);
    check("overrun_sticky", 64'(bus.overrun), 64'(1));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
